// File: rtl/text_writer.sv
// Character-plane text writer: turns a byte stream into registered plane writes,
// tracks a wrapping cursor and supports backspace, newline, form-feed clear and an escaped status cell.
module text_writer #(
  parameter int          COLS  = 20,
  parameter int          ROWS  = 7,
  parameter logic [7:0]  BLANK = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       ready,
  output logic [7:0] din,
  output logic [5:0] cin,
  output logic [3:0] rin,
  output logic       we,
  output logic       s,
  output logic [5:0] cur_col,
  output logic [3:0] cur_row,
  output logic [1:0] state_o
);

  // Handshake: a byte transfers on a posedge where rx_valid=1 and ready=1; a byte
  // offered while ready=0 is dropped, the sender must hold it until ready is seen high.

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    ESC_WAIT = 2'd2,
    CLEAR    = 2'd3
  } state_t;

  localparam logic [5:0] LAST_COL = 6'(COLS - 1);
  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

  state_t     state_q, state_d;
  logic [5:0] col_q, col_d;
  logic [3:0] row_q, row_d;
  logic       adv_q, adv_d;
  logic       ready_q, ready_d;
  logic       we_q, we_d;
  logic       s_q, s_d;
  logic [7:0] din_q, din_d;
  logic [5:0] cin_q, cin_d;
  logic [3:0] rin_q, rin_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      adv_q   <= 1'b0;
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      s_q     <= 1'b0;
      din_q   <= '0;
      cin_q   <= '0;
      rin_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      adv_q   <= adv_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      s_q     <= s_d;
      din_q   <= din_d;
      cin_q   <= cin_d;
      rin_q   <= rin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    adv_d   = adv_q;
    we_d    = 1'b0;
    s_d     = 1'b0;
    din_d   = din_q;
    cin_d   = cin_q;
    rin_d   = rin_q;

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data >= 8'h20 && rx_data <= 8'h7E) begin
            we_d    = 1'b1;
            din_d   = rx_data;
            cin_d   = col_q;
            rin_d   = row_q;
            adv_d   = 1'b1;
            state_d = WRITE;
          end else begin
            case (rx_data)
              8'h08: begin
                if (col_q != 6'd0 || row_q != 4'd0) begin
                  if (col_q == 6'd0) begin
                    col_d = LAST_COL;
                    row_d = row_q - 4'd1;
                  end else begin
                    col_d = col_q - 6'd1;
                  end
                  we_d    = 1'b1;
                  din_d   = BLANK;
                  cin_d   = col_d;
                  rin_d   = row_d;
                  adv_d   = 1'b0;
                  state_d = WRITE;
                end
              end
              8'h0A, 8'h0D: begin
                col_d = 6'd0;
                row_d = (row_q == LAST_ROW) ? 4'd0 : row_q + 4'd1;
              end
              8'h0C: begin
                // The clear walker reuses the plane address registers as its counter.
                we_d    = 1'b1;
                din_d   = BLANK;
                cin_d   = 6'd0;
                rin_d   = 4'd0;
                state_d = CLEAR;
              end
              8'h1B: state_d = ESC_WAIT;
              default: ;
            endcase
          end
        end
      end

      ESC_WAIT: begin
        if (rx_valid) begin
          we_d    = 1'b1;
          s_d     = 1'b1;
          din_d   = rx_data;
          cin_d   = 6'd0;
          rin_d   = LAST_ROW;
          adv_d   = 1'b0;
          state_d = WRITE;
        end
      end

      WRITE: begin
        if (adv_q) begin
          if (col_q == LAST_COL) begin
            col_d = 6'd0;
            row_d = (row_q == LAST_ROW) ? 4'd0 : row_q + 4'd1;
          end else begin
            col_d = col_q + 6'd1;
          end
        end
        state_d = IDLE;
      end

      CLEAR: begin
        if (cin_q == LAST_COL && rin_q == LAST_ROW) begin
          col_d   = 6'd0;
          row_d   = 4'd0;
          state_d = IDLE;
        end else begin
          we_d  = 1'b1;
          din_d = BLANK;
          if (cin_q == LAST_COL) begin
            cin_d = 6'd0;
            rin_d = rin_q + 4'd1;
          end else begin
            cin_d = cin_q + 6'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE) || (state_d == ESC_WAIT);
  end

  assign ready   = ready_q;
  assign we      = we_q;
  assign s       = s_q;
  assign din     = din_q;
  assign cin     = cin_q;
  assign rin     = rin_q;
  assign cur_col = col_q;
  assign cur_row = row_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_text_writer.sv
// Bench for text_writer: directed scenarios with literal expectations plus randomized
// byte streams, all checked every cycle against a queue-based behavioural model.
module tb_text_writer;

  localparam int         COLS  = 20;
  localparam int         ROWS  = 7;
  localparam logic [7:0] BLANK = 8'hFF;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       ready, we, s;
  logic [7:0] din;
  logic [5:0] cin, cur_col;
  logic [3:0] rin, cur_row;
  logic [1:0] state_o;

  text_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK(BLANK)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .ready(ready), .din(din), .cin(cin), .rin(rin), .we(we), .s(s),
    .cur_col(cur_col), .cur_row(cur_row), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Each accepted byte expands into a list of plane writes (s, din, col, row);
  // every displayed write is one cycle with ready low.
  logic [18:0] exp_q[$];
  int  m_col, m_row, p_col, p_row;
  bit  m_esc, m_active;
  bit  e_we, e_s, e_ready;
  int  e_din, e_cin, e_rin;

  function automatic void model_reset();
    m_col = 0; m_row = 0; p_col = 0; p_row = 0;
    m_esc = 0; m_active = 0;
    exp_q.delete();
    e_we = 0; e_s = 0; e_ready = 1; e_din = 0; e_cin = 0; e_rin = 0;
  endfunction

  function automatic void show_beat();
    logic [18:0] b;
    b = exp_q.pop_front();
    e_we = 1; e_ready = 0; m_active = 1;
    e_s = b[18]; e_din = int'(b[17:10]); e_cin = int'(b[9:4]); e_rin = int'(b[3:0]);
  endfunction

  function automatic void show_idle();
    e_we = 0; e_s = 0; e_ready = 1; m_active = 0;
  endfunction

  function automatic void take_byte(input logic [7:0] b);
    int idx;
    bit deferred;
    deferred = 0;
    if (m_esc) begin
      m_esc = 0;
      exp_q.push_back({1'b1, b, 6'd0, 4'd0});
    end else if (b >= 8'h20 && b <= 8'h7E) begin
      exp_q.push_back({1'b0, b, 6'(m_col), 4'(m_row)});
      idx = (m_row * COLS + m_col + 1) % (ROWS * COLS);
      p_col = idx % COLS; p_row = idx / COLS;
      deferred = 1;
    end else if (b == 8'h08) begin
      idx = m_row * COLS + m_col;
      if (idx > 0) begin
        idx--;
        m_col = idx % COLS; m_row = idx / COLS;
        exp_q.push_back({1'b0, BLANK, 6'(m_col), 4'(m_row)});
      end
    end else if (b == 8'h0A || b == 8'h0D) begin
      m_col = 0; m_row = (m_row + 1) % ROWS;
    end else if (b == 8'h0C) begin
      for (int i = 0; i < ROWS * COLS; i++)
        exp_q.push_back({1'b0, BLANK, 6'(i % COLS), 4'(i / COLS)});
      p_col = 0; p_row = 0;
      deferred = 1;
    end else if (b == 8'h1B) begin
      m_esc = 1;
    end
    if (!deferred) begin
      p_col = m_col; p_row = m_row;
    end
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else if (m_active) begin
      if (exp_q.size() > 0) show_beat();
      else begin
        m_col = p_col; m_row = p_row;
        show_idle();
      end
    end else begin
      show_idle();
      if (rx_valid) begin
        take_byte(rx_data);
        if (exp_q.size() > 0) show_beat();
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    bit ok;
    ok = (we === e_we) && (ready === e_ready) &&
         (int'(cur_col) == m_col) && (int'(cur_row) == m_row);
    if (e_we) begin
      ok = ok && (s === e_s) && (int'(din) == e_din);
      if (!e_s) ok = ok && (int'(cin) == e_cin) && (int'(rin) == e_rin);
    end
    checks++;
    if (ok) passed++;
    else $display("FAIL model_cmp t=%0t: got we=%0b rdy=%0b s=%0b din=%02h c=%0d r=%0d cur=(%0d,%0d) expected we=%0b rdy=%0b s=%0b din=%02h c=%0d r=%0d cur=(%0d,%0d)",
                  $time, we, ready, s, din, cin, rin, cur_col, cur_row,
                  e_we, e_ready, e_s, e_din[7:0], e_cin, e_rin, m_col, m_row);
  end

  // ---------------- drivers ----------------
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("ready_timeout", 0, 1);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic check_cursor(input string name, input int col, input int row);
    check({name, "_col"}, int'(cur_col), col);
    check({name, "_row"}, int'(cur_row), row);
  endtask

  function automatic logic [7:0] pick();
    int r;
    r = $urandom_range(0, 99);
    if (r < 50) return 8'($urandom_range(32, 126));
    if (r < 58) return 8'h08;
    if (r < 64) return ($urandom_range(0, 1) != 0) ? 8'h0A : 8'h0D;
    if (r < 66) return 8'h0C;
    if (r < 72) return 8'h1B;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    int n;
    int rst_cnt;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_we", we, 0);
    check("rst_s", s, 0);
    check("rst_din", din, 0);
    check("rst_cin", cin, 0);
    check("rst_rin", rin, 0);
    check_cursor("rst", 0, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // 'A' right after reset
    send(8'h41);
    @(negedge clk);
    check("a_we", we, 1);
    check("a_din", din, 8'h41);
    check("a_cin", cin, 0);
    check("a_rin", rin, 0);
    check("a_ready", ready, 0);
    @(negedge clk);
    check("a_we_after", we, 0);
    check("a_ready_after", ready, 1);
    check_cursor("a", 1, 0);

    // Walk to (19,6), then 'Z' wraps to origin
    repeat (6) send(8'h0A);
    repeat (19) send(8'($urandom_range(32, 126)));
    repeat (2) @(negedge clk);
    check_cursor("pre_z", 19, 6);
    send(8'h5A);
    @(negedge clk);
    check("z_we", we, 1);
    check("z_cin", cin, 19);
    check("z_rin", rin, 6);
    @(negedge clk);
    check_cursor("z_wrap", 0, 0);

    // Backspace from (0,2)
    repeat (2) send(8'h0D);
    send(8'h08);
    @(negedge clk);
    check("bs_we", we, 1);
    check("bs_din", din, 8'hFF);
    check("bs_cin", cin, 19);
    check("bs_rin", rin, 1);
    @(negedge clk);
    check_cursor("bs", 19, 1);

    // Full clear
    send(8'h0C);
    n = 0;
    @(negedge clk);
    while (we && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("clear_len", n, ROWS * COLS);
    check_cursor("clear", 0, 0);
    check("clear_ready", ready, 1);

    // Backspace at origin does nothing
    send(8'h08);
    repeat (3) begin
      @(negedge clk);
      check("bs0_we", we, 0);
    end
    check_cursor("bs0", 0, 0);

    // Escaped status write
    send(8'h51);
    send(8'h1B);
    send(8'h35);
    @(negedge clk);
    check("esc_we", we, 1);
    check("esc_s", s, 1);
    check("esc_din", din, 8'h35);
    @(negedge clk);
    check_cursor("esc", 1, 0);

    // CR at (7,3)
    repeat (3) send(8'h0A);
    repeat (7) send(8'($urandom_range(32, 126)));
    repeat (2) @(negedge clk);
    check_cursor("pre_cr", 7, 3);
    send(8'h0D);
    @(negedge clk);
    check("cr_we", we, 0);
    check_cursor("cr", 0, 4);

    // Reset in the 50th clear cycle
    send(8'h0C);
    repeat (50) @(negedge clk);
    check("clr50_we", we, 1);
    check("clr50_cin", cin, 9);
    check("clr50_rin", rin, 2);
    #2 reset = 1'b1;
    #1;
    check("midrst_we", we, 0);
    check("midrst_ready", ready, 1);
    check_cursor("midrst", 0, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    send(8'h42);
    @(negedge clk);
    check("b_we", we, 1);
    check("b_din", din, 8'h42);
    check("b_cin", cin, 0);
    check("b_rin", rin, 0);

    // Randomized stream with occasional resets
    rst_cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) reset = 1'b0;
      end else if ($urandom_range(0, 799) == 0) begin
        reset = 1'b1;
        rst_cnt = 2;
      end
      rx_valid = ($urandom_range(0, 2) != 0);
      rx_data  = pick();
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
    reset = 1'b0;
    repeat (200) @(posedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/text_writer.md
TEXT_WRITER -- requirements
Module: text_writer

Interface
REQ-001 Parameter COLS, default 20, number of character columns per row.
REQ-002 Parameter ROWS, default 7, number of character rows.
REQ-003 Parameter BLANK, default 8'hFF, erase code driven on din (the plane stores it as its blank glyph).
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 rx_data  input  8  incoming character byte.
REQ-007 rx_valid  input  1  rx_data valid; byte accepted on a posedge where rx_valid=1 and ready=1.
REQ-008 ready  output  1  block can accept a byte this cycle.
REQ-009 din  output  8  data to the character plane.
REQ-010 cin  output  6  target column to the character plane.
REQ-011 rin  output  4  target row to the character plane.
REQ-012 we  output  1  plane write strobe, registered, one cycle per write.
REQ-013 s  output  1  status-cell select; when 1 with we=1, the plane writes din to row ROWS-1, column 0.
REQ-014 cur_col  output  6 and cur_row  output  4  current cursor position, for caret display.

Function
REQ-015 All outputs SHALL be registered; din/cin/rin/s SHALL be stable for the full cycle in which we=1, so the plane's negedge write samples settled values.
REQ-016 The FSM SHALL have states IDLE, WRITE, ESC_WAIT and CLEAR; ready=1 only in IDLE and ESC_WAIT.
REQ-017 In IDLE, on accepting a byte 0x20..0x7E: drive we=1, s=0, din=byte, cin=cur_col, rin=cur_row, and go to WRITE.
REQ-018 In WRITE: drive we=0; advance the cursor one cell (col+1; at col COLS-1 -> col 0, row+1; at (COLS-1, ROWS-1) -> (0,0)); return to IDLE. Each printable byte therefore costs 2 cycles.
REQ-019 Backspace 0x08: if the cursor is not (0,0), move the cursor back one cell (col 0 -> col COLS-1 of the previous row) and write din=BLANK at the new position via WRITE, without advancing afterwards; at (0,0), perform no write and no move, and remain in IDLE.
REQ-020 CR 0x0D or LF 0x0A: no write; set col=0 and row=row+1 (ROWS-1 wraps to 0); remain in IDLE, ready continuously 1.
REQ-021 Form feed 0x0C: enter CLEAR and write din=BLANK to every cell in row-major order from (0,0) to (COLS-1, ROWS-1), one cell per cycle with we held 1 (ROWS*COLS=140 cycles); then drive we=0, set cursor (0,0) and return to IDLE.
REQ-022 ESC 0x1B: enter ESC_WAIT; the next accepted byte (any value) SHALL be written with s=1, we=1, din=byte for one cycle, without moving the cursor; then return to IDLE through WRITE (cursor unchanged).
REQ-023 All other byte values SHALL be accepted and discarded with no write.
REQ-024 rx_valid while ready=0 SHALL be ignored; no byte buffering is provided.
REQ-025 Cursor arithmetic SHALL never produce col>=COLS or row>=ROWS.

Reset
REQ-026 Asserting reset SHALL immediately force state=IDLE, we=0, s=0, din=0, cin=0, rin=0, cursor (0,0), ready=1, including mid-CLEAR or in ESC_WAIT; partially cleared cells remain as written.
REQ-027 The first edge after reset deassertion SHALL accept a byte.

Verification
REQ-028 Reset, then send 'A' (0x41) -> one cycle with we=1, din=0x41, cin=0, rin=0; cursor becomes (1,0); ready low for exactly 1 cycle.
REQ-029 Cursor at (19,6), send 'Z' -> write at (19,6); cursor wraps to (0,0).
REQ-030 Cursor at (0,2), send 0x08 -> we=1, din=0xFF, cin=19, rin=1; cursor (19,1). Cursor at (0,0), send 0x08 -> no write.
REQ-031 Send 0x0C -> exactly 140 consecutive we=1 cycles, din=0xFF, addresses (0,0)..(19,6) in order; then cursor (0,0), ready=1.
REQ-032 Send 0x1B then 0x35 -> one write with s=1, din=0x35; cursor unchanged; 0x0D at (7,3) -> cursor (0,4), no write.
REQ-033 Assert reset at the 50th CLEAR cycle -> we=0 immediately, cursor (0,0), ready=1; a following 'B' is written at (0,0).
